// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline package: hazard FSM state encoding, the x0 register index
// and the load-use hazard predicate.
package riscv_pipe_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    localparam logic [4:0] X0 = 5'd0;

    // Writes to x0 are discarded, so a load targeting x0 never creates a dependency.
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != X0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_stats.sv
// Free-running 32-bit event counters for load-use stalls and accepted redirects.
// Only instantiated by hazard_ctrl when HAZARD_STATS_EN is defined.
module hazard_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt_i,
    input  logic        redir_evt_i,
    output logic [31:0] stall_count_o,
    output logic [31:0] flush_count_o
);

    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (stall_evt_i) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redir_evt_i) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_count_o = stall_q;
    assign flush_count_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, control-transfer redirect and
// wrong-path flush window. Optional stats counters under HAZARD_STATS_EN.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [31:0] ex_target,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [2:0] flush_cnt_q;
    logic [2:0] flush_cnt_d;
    logic       redirect_s;
    logic       load_use_s;

    assign redirect_s  = ex_branch_taken | ex_jal | ex_jalr;
    assign load_use_s  = is_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2);
    assign redirect_pc = ex_target;

    // State register and flush-window counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and pipeline control; reset forces both flushes so no stale
    // instruction survives while the core is held.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_flush       = 1'b0;
        redirect_valid = 1'b0;
        if (rst) begin
            state_d     = ST_RUN;
            flush_cnt_d = 3'd0;
            if_id_flush = 1'b1;
            id_flush    = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_s) begin
                        redirect_valid = 1'b1;
                        if_id_flush    = 1'b1;
                        id_flush       = 1'b1;
                        if (FLUSH_INIT != 3'd0) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end else begin
                            state_d     = ST_RUN;
                            flush_cnt_d = 3'd0;
                        end
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_flush    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Inputs here belong to wrong-path instructions and are ignored.
                    if_id_flush = 1'b1;
                    id_flush    = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_evt_s;
    logic redir_evt_s;

    assign redir_evt_s = !rst && (state_q == ST_RUN) && redirect_s;
    assign stall_evt_s = !rst && (state_q == ST_RUN) && !redirect_s && load_use_s;

    hazard_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .stall_evt_i   (stall_evt_s),
        .redir_evt_i   (redir_evt_s),
        .stall_count_o (stall_count),
        .flush_count_o (flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (FLUSH_CYCLES = 1, 3, 0)
// share stimulus and are compared against a remaining-flush-cycles model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_uses_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_branch_taken = 1'b0;
    logic        ex_jal = 1'b0;
    logic        ex_jalr = 1'b0;
    logic [31:0] ex_target = 32'd0;

    // Per instance g: {pc_write, if_id_write, if_id_flush, id_flush, redirect_valid}
    wire [14:0]  ctl_all;
    wire [95:0]  rpc_all;
`ifdef HAZARD_STATS_EN
    wire [95:0]  stall_all;
    wire [95:0]  flushc_all;
`endif

    localparam logic [4:0] C_RESET  = 5'b11110;
    localparam logic [4:0] C_FLUSH  = 5'b11110;
    localparam logic [4:0] C_REDIR  = 5'b11111;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_NORMAL = 5'b11000;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned P = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        hazard_ctrl #(.FLUSH_CYCLES(P)) dut (
            .clk             (clk),
            .rst             (rst),
            .id_rs1          (id_rs1),
            .id_rs2          (id_rs2),
            .id_uses_rs2     (id_uses_rs2),
            .ex_mem_read     (ex_mem_read),
            .ex_rd           (ex_rd),
            .ex_branch_taken (ex_branch_taken),
            .ex_jal          (ex_jal),
            .ex_jalr         (ex_jalr),
            .ex_target       (ex_target),
            .pc_write        (ctl_all[g*5+4]),
            .if_id_write     (ctl_all[g*5+3]),
            .if_id_flush     (ctl_all[g*5+2]),
            .id_flush        (ctl_all[g*5+1]),
            .redirect_valid  (ctl_all[g*5+0]),
            .redirect_pc     (rpc_all[g*32 +: 32])
`ifdef HAZARD_STATS_EN
            ,
            .stall_count     (stall_all[g*32 +: 32]),
            .flush_count     (flushc_all[g*32 +: 32])
`endif
        );
    end

    always #5 clk = ~clk;

    // Reference model: cycles of wrong-path flushing still owed per instance.
    int          flush_len [3] = '{1, 3, 0};
    int          rem [3] = '{0, 0, 0};
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_redirs = 32'd0;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic bit m_redir();
        return ex_branch_taken || ex_jal || ex_jalr;
    endfunction

    function automatic bit m_load_use();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

    function automatic logic [4:0] exp_ctl(int k);
        if (rst)          return C_RESET;
        if (rem[k] > 0)   return C_FLUSH;
        if (m_redir())    return C_REDIR;
        if (m_load_use()) return C_STALL;
        return C_NORMAL;
    endfunction

    function automatic logic [14:0] exp_all();
        return {exp_ctl(2), exp_ctl(1), exp_ctl(0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_stalls = 32'd0;
            m_redirs = 32'd0;
        end else if (rem[0] == 0) begin
            if (m_redir()) m_redirs = m_redirs + 32'd1;
            else if (m_load_use()) m_stalls = m_stalls + 32'd1;
        end
        for (int k = 0; k < 3; k++) begin
            if (rst)             rem[k] = 0;
            else if (rem[k] > 0) rem[k] = rem[k] - 1;
            else if (m_redir())  rem[k] = flush_len[k];
        end
        #1;
    endtask

    task automatic idle();
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs2 = 1'b0; ex_branch_taken = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        ex_target = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ex_jal = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl_all !== {C_RESET, C_RESET, C_RESET}) $display("FAIL reset_ctl got=%b want=%b", ctl_all, {C_RESET, C_RESET, C_RESET});
        else n_pass++;
        n_chk++;
        if (rpc_all[31:0] !== ex_target) $display("FAIL reset_pc got=%h want=%h", rpc_all[31:0], ex_target);
        else n_pass++;
        tick();
        idle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl_all !== {C_NORMAL, C_NORMAL, C_NORMAL}) $display("FAIL after_reset got=%b want=%b", ctl_all, {C_NORMAL, C_NORMAL, C_NORMAL});
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_STALL) $display("FAIL load_use_stall got=%b want=%b", ctl_all[4:0], C_STALL);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_NORMAL) $display("FAIL load_use_resume got=%b want=%b", ctl_all[4:0], C_NORMAL);
        else n_pass++;
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs1 = 5'd3; id_uses_rs2 = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_STALL) $display("FAIL load_use_rs2 got=%b want=%b", ctl_all[4:0], C_STALL);
        else n_pass++;
        tick();
        id_uses_rs2 = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_NORMAL) $display("FAIL rs2_unused got=%b want=%b", ctl_all[4:0], C_NORMAL);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl_all !== {C_NORMAL, C_NORMAL, C_NORMAL}) $display("FAIL x0_no_stall got=%b want=%b", ctl_all, {C_NORMAL, C_NORMAL, C_NORMAL});
        else n_pass++;
        tick();
    endtask

    task automatic test_jal();
        idle();
        ex_jal = 1'b1; ex_target = 32'h0000_0040;
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_REDIR || rpc_all[31:0] !== 32'h0000_0040)
            $display("FAIL jal_redirect got=%b/%h want=%b/00000040", ctl_all[4:0], rpc_all[31:0], C_REDIR);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_FLUSH) $display("FAIL jal_flush got=%b want=%b", ctl_all[4:0], C_FLUSH);
        else n_pass++;
        n_chk++;
        if (ctl_all[14:10] !== C_NORMAL) $display("FAIL jal_noflush_p0 got=%b want=%b", ctl_all[14:10], C_NORMAL);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_NORMAL) $display("FAIL jal_back_to_run got=%b want=%b", ctl_all[4:0], C_NORMAL);
        else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_priority();
        idle();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        @(negedge clk);
        n_chk++;
        if (ctl_all[4:0] !== C_REDIR) $display("FAIL redirect_priority got=%b want=%b", ctl_all[4:0], C_REDIR);
        else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_rst_mid_flush();
        idle();
        ex_jalr = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl_all[9:5] !== C_REDIR) $display("FAIL jalr_enter got=%b want=%b", ctl_all[9:5], C_REDIR);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_chk++;
        if (ctl_all[9:5] !== C_FLUSH) $display("FAIL flush3_cyc1 got=%b want=%b", ctl_all[9:5], C_FLUSH);
        else n_pass++;
        tick();
        ex_jalr = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl_all[9:5] !== C_RESET) $display("FAIL flush3_rst got=%b want=%b", ctl_all[9:5], C_RESET);
        else n_pass++;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        n_chk++;
        if (ctl_all !== {C_NORMAL, C_NORMAL, C_NORMAL}) $display("FAIL run_after_rst got=%b want=%b", ctl_all, {C_NORMAL, C_NORMAL, C_NORMAL});
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 40) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 15) == 0);
            ex_jal          = ($urandom_range(0, 23) == 0);
            ex_jalr         = ($urandom_range(0, 23) == 0);
            ex_target       = $urandom;
            @(negedge clk);
            n_chk++;
            if (ctl_all !== exp_all()) $display("FAIL random_ctl i=%0d got=%b want=%b", i, ctl_all, exp_all());
            else n_pass++;
            n_chk++;
            if (rpc_all !== {ex_target, ex_target, ex_target}) $display("FAIL random_pc i=%0d got=%h want=%h", i, rpc_all, {ex_target, ex_target, ex_target});
            else n_pass++;
`ifdef HAZARD_STATS_EN
            n_chk++;
            if (stall_all[31:0] !== m_stalls || flushc_all[31:0] !== m_redirs)
                $display("FAIL random_stats i=%0d got=%0d/%0d want=%0d/%0d", i, stall_all[31:0], flushc_all[31:0], m_stalls, m_redirs);
            else n_pass++;
`endif
            tick();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12;
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            ex_jal = 1'b1;
            tick();
            idle();
            for (int j = 0; j < 3; j++) tick();
        end
        @(negedge clk);
        n_chk++;
        if (stall_all[31:0] !== 32'd3 || flushc_all[31:0] !== 32'd2)
            $display("FAIL stats_counts got=%0d/%0d want=3/2", stall_all[31:0], flushc_all[31:0]);
        else n_pass++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_load_use();
        test_x0();
        test_jal();
        test_priority();
        test_rst_mid_flush();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
